// File: rtl/vec_pkg.sv
// vec_pkg: shared vector-unit constants and the store-serializer state encoding.
//   VEC_LANES / VEC_REGS : architectural lanes per vector / number of vector registers
//   LANE_BITS / VREG_BITS: index widths reused by the register file and decode logic
package vec_pkg;
    localparam int VEC_LANES = 16;
    localparam int VEC_REGS  = 16;
    localparam int LANE_BITS = $clog2(VEC_LANES);
    localparam int VREG_BITS = $clog2(VEC_REGS);
    typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} vss_state_t;
endpackage

// File: rtl/vector_store_serializer_if.sv
// vector_store_serializer_if: scalar memory-write beat channel (valid/ready).
//   mem_valid/mem_addr/mem_wdata : driven by the master (serializer)
//   mem_ready                    : driven by the slave (data memory)
interface vector_store_serializer_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    modport master (output mem_valid, mem_addr, mem_wdata, input mem_ready);
    modport slave  (input mem_valid, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/vector_store_serializer.sv
// vector_store_serializer: snapshots one vector register and streams its lanes as scalar memory writes.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start/vreg/base_addr : store request, source register, word address of lane 0
//   v_sel / vd       : register-file read index and its combinational read data
//   mem              : beat channel master (valid/ready, addr, wdata)
//   busy / done      : activity flag, one-cycle completion pulse
module vector_store_serializer
    import vec_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int VECTOR_SIZE  = VEC_LANES,
    parameter int NUM_VECTORES = VEC_REGS,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [$clog2(NUM_VECTORES)-1:0]      vreg,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    output logic [$clog2(NUM_VECTORES)-1:0]      v_sel,
    input  logic [VECTOR_SIZE-1:0][WIDTH-1:0]    vd,
    vector_store_serializer_if.master            mem,
    output logic                                 busy,
    output logic                                 done
);
    vss_state_t                       state, state_nxt;
    logic [LANE_BITS-1:0]             lane;
    logic [ADDR_WIDTH-1:0]            base;
    logic [VECTOR_SIZE-1:0][WIDTH-1:0] snap;
    logic                             fire;
    logic                             last;

    assign fire = mem.mem_valid && mem.mem_ready;
    assign last = lane == LANE_BITS'(VECTOR_SIZE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs decode from state only, so an asynchronous reset clears them at once.
    always_comb begin
        state_nxt     = state;
        mem.mem_valid = state == SEND;
        mem.mem_addr  = state == SEND ? base + ADDR_WIDTH'(lane) : '0;
        mem.mem_wdata = state == SEND ? snap[lane] : '0;
        busy          = state != IDLE;
        done          = state == DONE;
        case (state)
            IDLE:    state_nxt = start ? CAPTURE : IDLE;
            CAPTURE: state_nxt = SEND;
            SEND:    state_nxt = fire && last ? DONE : SEND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sel <= '0;
            base  <= '0;
            lane  <= '0;
        end else if (state == IDLE && start) begin
            v_sel <= vreg;
            base  <= base_addr;
            lane  <= '0;
        end else if (state == SEND && fire) begin
            lane  <= lane + LANE_BITS'(1);
        end
    end

    // Snapshot needs no reset; it is always refilled before SEND reads it.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) snap <= vd;
    end
endmodule

// File: tb/tb_vector_store_serializer.sv
// tb_vector_store_serializer: directed checks of the vector store serializer.
module tb_vector_store_serializer;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [3:0]           vreg = '0;
    logic [15:0]          base_addr = '0;
    logic [3:0]           v_sel;
    logic [15:0][15:0]    vd;
    logic                 busy;
    logic                 done;
    logic [15:0][15:0]    rf [16];
    logic [15:0][15:0]    v3;
    int                   n_chk = 0;
    int                   n_pass = 0;

    vector_store_serializer_if #(.WIDTH(16), .ADDR_WIDTH(16)) mem_if ();

    vector_store_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vreg      (vreg),
        .base_addr (base_addr),
        .v_sel     (v_sel),
        .vd        (vd),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign vd = rf[v_sel];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // mode: 0 plain, 1 ready low every other cycle, 2 overwrite source after capture,
    //       3 extra start mid-send, 4 reset after five beats
    task automatic run_store(input logic [3:0] vr, input logic [15:0] ba,
                             input logic [15:0][15:0] ev, input int mode);
        int beat = 0;
        int stalls = 0;
        int done_cyc = -1;
        int extra = 0;
        logic [15:0] a;
        start = 1'b1;
        vreg = vr;
        base_addr = ba;
        @(posedge clk);
        #1;
        start = 1'b0;
        vreg = ~vr;
        base_addr = ~ba;
        for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
            mem_if.mem_ready = (mode == 1) ? ((cyc % 2) == 1) : 1'b1;
            if (mode == 2 && cyc == 2) rf[vr] = {16{16'hFFFF}};
            if (mode == 3) begin
                start = (cyc == 5);
                vreg = 4'd5;
            end
            if (mode == 4 && beat == 5) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", mem_if.mem_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                return;
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk("capture_busy", busy, 1);
                chk("capture_valid", mem_if.mem_valid, 0);
                chk("v_sel", v_sel, vr);
            end
            if (done) done_cyc = cyc;
            else if (cyc >= 2 && beat < 16) begin
                a = ba + 16'(beat);
                chk("valid", mem_if.mem_valid, 1);
                chk("addr", mem_if.mem_addr, a);
                chk("wdata", mem_if.mem_wdata, ev[beat]);
                if (mem_if.mem_ready) beat++;
                else stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("beats", beat, 16);
        chk("done_cycle", done_cyc, 18 + stalls);
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
        @(posedge clk);
        #1;
        if (mode == 3) begin
            start = 1'b0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            chk("no_second_store", extra, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        for (int j = 0; j < 16; j++) begin
            v3[j] = 16'h0300 + 16'(j);
            rf[5][j] = 16'h0500 + 16'(j);
        end
        rf[3] = v3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", mem_if.mem_valid, 0);
        chk("reset_addr", mem_if.mem_addr, 0);
        chk("reset_wdata", mem_if.mem_wdata, 0);
        chk("reset_v_sel", v_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_store(4'd3, 16'h0100, v3, 0);
        run_store(4'd3, 16'h0100, v3, 1);
        run_store(4'd3, 16'h0100, v3, 2);
        rf[3] = v3;
        run_store(4'd0, 16'hFFF8, '0, 0);
        run_store(4'd3, 16'h0100, v3, 3);
        run_store(4'd3, 16'h0100, v3, 4);
        @(posedge clk);
        #1;
        chk("held_busy", busy, 0);
        chk("held_valid", mem_if.mem_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", busy, 0);
        run_store(4'd3, 16'h0200, v3, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
